ray_generator: RTL and testbench
================================

RAY_GENERATOR -- requirements
Module: ray_generator

Interface
REQ-001 SHALL have parameters: POSITION_WIDTH, 16, vector component width; ADDRESS_WIDTH, 32, byte-address width; PIXEL_BYTES, 4, frame-buffer bytes per pixel.
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 Ports SHALL be:
 clock  in  1  rising-edge clock
 resetN  in  1  synchronous active-low reset
 start  in  1  one-cycle pulse, begin frame
 flush  in  1  one-cycle pulse, abort frame
 width  in  12  frame width in pixels
 height  in  12  frame height in pixels
 frameAddress  in  ADDRESS_WIDTH  byte address of pixel (0,0)
 cameraQ  in  3xPOSITION_WIDTH  camera origin
 cameraV  in  3xPOSITION_WIDTH  direction of pixel (0,0)
 cameraX  in  3xPOSITION_WIDTH  per-column direction step
 cameraY  in  3xPOSITION_WIDTH  per-row direction step
 rayValid  out  1  ray beat valid
 rayTaken  in  1  downstream accepts beat
 rayOrigin  out  3xPOSITION_WIDTH  ray origin
 rayDirection  out  3xPOSITION_WIDTH  ray direction
 rayPixelAddress  out  ADDRESS_WIDTH  destination byte address
 rayLast  out  1  final ray of frame
 ready  out  1  idle, accepts start
 busy  out  1  frame in progress

Function
REQ-004 SHALL implement states IDLE, LOAD, EMIT.
REQ-005 IDLE: ready=1, busy=0, rayValid=0. On start, go to LOAD.
REQ-006 LOAD (one cycle): SHALL latch all config inputs, set x=0, y=0, rowDir=cameraV, dir=cameraV, addr=frameAddress. If width==0 or height==0, go to IDLE with no rays emitted; else go to EMIT.
REQ-007 EMIT: rayValid=1, busy=1, ready=0. Outputs come from registers only and SHALL hold stable while rayValid && !rayTaken.
REQ-008 A beat transfers on a cycle with rayValid && rayTaken. The first beat SHALL be valid the cycle after LOAD. Sustained throughput SHALL be one ray per cycle.
REQ-009 On transfer with x<width-1: x+=1, dir+=cameraX (latched), addr+=PIXEL_BYTES.
REQ-010 On transfer with x==width-1 and y<height-1: x=0, y+=1, rowDir+=cameraY, dir=rowDir+cameraY, addr+=PIXEL_BYTES.
REQ-011 On transfer with rayLast=1: go to IDLE; ready SHALL be high the next cycle.
REQ-012 rayLast SHALL be 1 only when x==width-1 and y==height-1.
REQ-013 rayOrigin SHALL equal the latched cameraQ for every beat.
REQ-014 Direction arithmetic SHALL be per-component, POSITION_WIDTH wide, modulo 2^POSITION_WIDTH, with no multipliers. Address arithmetic SHALL be modulo 2^ADDRESS_WIDTH.
REQ-015 start SHALL be ignored outside IDLE. Config input changes after LOAD SHALL have no effect until the next start.
REQ-016 flush in any state SHALL force IDLE next cycle with rayValid=0, discarding the pending beat. flush SHALL take priority over start and rayTaken in the same cycle.

Reset
REQ-017 While resetN==0 at a clock edge: state=IDLE, rayValid=0, rayLast=0, busy=0, ready=1.
REQ-018 On reset, x, y, dir, rowDir, addr, and the latched config SHALL be cleared to 0, so all data outputs read 0.
REQ-019 Reset mid-frame SHALL abandon the frame; no beat is valid in the cycle after reset deasserts.

Structure
REQ-020 Package ray_pkg SHALL hold POSITION_WIDTH default, vec3 typedef (3xPOSITION_WIDTH), and the state enum.
REQ-021 A sub-module vec3_add (combinational per-component modular add) SHALL be used for the dir and rowDir updates.

Verification
REQ-022 Basic frame: width=2, height=2, cameraQ=(5,6,7), V=(0,0,100), X=(1,0,0), Y=(0,1,0), frameAddress=0x1000, rayTaken=1 -> directions (0,0,100),(1,0,100),(0,1,100),(1,1,100) on consecutive cycles; addresses 0x1000,0x1004,0x1008,0x100C; origin (5,6,7) on all; rayLast on 4th only; ready=1 next cycle.
REQ-023 Backpressure: same frame, rayTaken toggling 0/1 every cycle -> identical 4-ray sequence; outputs stable during stalls.
REQ-024 Degenerate frame: width=0, height=5, start -> rayValid never asserts; ready returns 2 cycles after start.
REQ-025 Wrap: V=(0xFFFF,0,0), X=(1,0,0), width=2, height=1 -> directions (0xFFFF,0,0) then (0,0,0).
REQ-026 Flush and restart: flush after 2nd beat of a 3x3 frame -> rayValid=0 next cycle, ready=1. A start pulse during busy is ignored. A new start then yields 9 fresh rays from pixel (0,0).

Source files
------------

// File: rtl/ray_pkg.sv
// Shared types for the ray generator: default vector width, packed 3-vector
// and the frame-walk state encoding.
package ray_pkg;

    localparam int POSITION_WIDTH_DEFAULT = 16;

    // Component 0 (x) occupies the least-significant slice.
    typedef logic [3*POSITION_WIDTH_DEFAULT-1:0] vec3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EMIT
    } state_t;

endpackage

// File: rtl/ray_generator_vec3_add.sv
// Per-component modular addition of two packed 3-vectors; carries never
// cross component boundaries.
module vec3_add
    import ray_pkg::*;
#(
    parameter int POSITION_WIDTH = POSITION_WIDTH_DEFAULT
) (
    input  logic [3*POSITION_WIDTH-1:0] a,
    input  logic [3*POSITION_WIDTH-1:0] b,
    output logic [3*POSITION_WIDTH-1:0] sum
);

    always_comb begin
        sum = '0;
        for (int i = 0; i < 3; i++) begin
            sum[i*POSITION_WIDTH +: POSITION_WIDTH] =
                a[i*POSITION_WIDTH +: POSITION_WIDTH] + b[i*POSITION_WIDTH +: POSITION_WIDTH];
        end
    end

endmodule

// File: rtl/ray_generator.sv
// Walks a width x height frame in raster order, emitting one camera ray per
// pixel with its frame-buffer address over a valid/taken handshake.
module ray_generator
    import ray_pkg::*;
#(
    parameter int POSITION_WIDTH = POSITION_WIDTH_DEFAULT,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int PIXEL_BYTES    = 4
) (
    input  logic                        clock,
    input  logic                        resetN,
    input  logic                        start,
    input  logic                        flush,
    input  logic [11:0]                 width,
    input  logic [11:0]                 height,
    input  logic [ADDRESS_WIDTH-1:0]    frameAddress,
    input  logic [3*POSITION_WIDTH-1:0] cameraQ,
    input  logic [3*POSITION_WIDTH-1:0] cameraV,
    input  logic [3*POSITION_WIDTH-1:0] cameraX,
    input  logic [3*POSITION_WIDTH-1:0] cameraY,
    output logic                        rayValid,
    input  logic                        rayTaken,
    output logic [3*POSITION_WIDTH-1:0] rayOrigin,
    output logic [3*POSITION_WIDTH-1:0] rayDirection,
    output logic [ADDRESS_WIDTH-1:0]    rayPixelAddress,
    output logic                        rayLast,
    output logic                        ready,
    output logic                        busy
);

    state_t                      state;
    logic [11:0]                 x, y;
    logic [11:0]                 widthR, heightR;
    logic [3*POSITION_WIDTH-1:0] camX, camY;
    logic [3*POSITION_WIDTH-1:0] rowDir;
    logic [3*POSITION_WIDTH-1:0] dirPlusX, rowPlusY;

    vec3_add #(.POSITION_WIDTH(POSITION_WIDTH)) u_step_x (
        .a   (rayDirection),
        .b   (camX),
        .sum (dirPlusX)
    );

    vec3_add #(.POSITION_WIDTH(POSITION_WIDTH)) u_step_y (
        .a   (rowDir),
        .b   (camY),
        .sum (rowPlusY)
    );

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state           <= IDLE;
            rayValid        <= 1'b0;
            rayLast         <= 1'b0;
            busy            <= 1'b0;
            ready           <= 1'b1;
            x               <= '0;
            y               <= '0;
            widthR          <= '0;
            heightR         <= '0;
            camX            <= '0;
            camY            <= '0;
            rowDir          <= '0;
            rayOrigin       <= '0;
            rayDirection    <= '0;
            rayPixelAddress <= '0;
        end else if (flush) begin
            state    <= IDLE;
            rayValid <= 1'b0;
            rayLast  <= 1'b0;
            busy     <= 1'b0;
            ready    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    widthR          <= width;
                    heightR         <= height;
                    camX            <= cameraX;
                    camY            <= cameraY;
                    rayOrigin       <= cameraQ;
                    rowDir          <= cameraV;
                    rayDirection    <= cameraV;
                    rayPixelAddress <= frameAddress;
                    x               <= '0;
                    y               <= '0;
                    if (width == 12'd0 || height == 12'd0) begin
                        state <= IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state    <= EMIT;
                        rayValid <= 1'b1;
                        rayLast  <= (width == 12'd1) && (height == 12'd1);
                    end
                end
                EMIT: begin
                    // rayValid is always high in EMIT, so rayTaken alone marks a transfer.
                    if (rayTaken) begin
                        if (rayLast) begin
                            state    <= IDLE;
                            rayValid <= 1'b0;
                            rayLast  <= 1'b0;
                            busy     <= 1'b0;
                            ready    <= 1'b1;
                        end else if (x != widthR - 12'd1) begin
                            x               <= x + 12'd1;
                            rayDirection    <= dirPlusX;
                            rayPixelAddress <= rayPixelAddress + ADDRESS_WIDTH'(PIXEL_BYTES);
                            rayLast         <= (x + 12'd1 == widthR - 12'd1) && (y == heightR - 12'd1);
                        end else begin
                            x               <= '0;
                            y               <= y + 12'd1;
                            rowDir          <= rowPlusY;
                            rayDirection    <= rowPlusY;
                            rayPixelAddress <= rayPixelAddress + ADDRESS_WIDTH'(PIXEL_BYTES);
                            rayLast         <= (widthR == 12'd1) && (y + 12'd1 == heightR - 12'd1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ray_generator.sv
// Randomised self-checking bench for ray_generator against a raster-order
// reference computed directly from V + x*X + y*Y and base + 4*(y*w + x).
module tb_ray_generator;
    import ray_pkg::*;

    localparam int PW = 16;
    localparam int AW = 32;

    logic          clock = 1'b0;
    logic          resetN = 1'b0;
    logic          start = 1'b0;
    logic          flush = 1'b0;
    logic          rayTaken = 1'b0;
    logic [11:0]   width = '0;
    logic [11:0]   height = '0;
    logic [AW-1:0] frameAddress = '0;
    vec3           cameraQ = '0, cameraV = '0, cameraX = '0, cameraY = '0;
    logic          rayValid, rayLast, ready, busy;
    vec3           rayOrigin, rayDirection;
    logic [AW-1:0] rayPixelAddress;

    ray_generator #(.POSITION_WIDTH(PW), .ADDRESS_WIDTH(AW), .PIXEL_BYTES(4)) dut (
        .clock           (clock),
        .resetN          (resetN),
        .start           (start),
        .flush           (flush),
        .width           (width),
        .height          (height),
        .frameAddress    (frameAddress),
        .cameraQ         (cameraQ),
        .cameraV         (cameraV),
        .cameraX         (cameraX),
        .cameraY         (cameraY),
        .rayValid        (rayValid),
        .rayTaken        (rayTaken),
        .rayOrigin       (rayOrigin),
        .rayDirection    (rayDirection),
        .rayPixelAddress (rayPixelAddress),
        .rayLast         (rayLast),
        .ready           (ready),
        .busy            (busy)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: expected beats of the current frame.
    vec3           mdir[$];
    logic [AW-1:0] maddr[$];
    logic          mlast[$];
    vec3           morigin;
    int            idx;

    function automatic vec3 vec(input int a, input int b, input int c);
        return {16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic set_config(input int w, input int h, input vec3 q, input vec3 v,
                              input vec3 xs, input vec3 ys, input logic [AW-1:0] base);
        vec3 d;
        width = 12'(w); height = 12'(h);
        cameraQ = q; cameraV = v; cameraX = xs; cameraY = ys;
        frameAddress = base;
        mdir.delete(); maddr.delete(); mlast.delete();
        morigin = q;
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                for (int c = 0; c < 3; c++)
                    d[c*PW +: PW] = 16'(int'(v[c*PW +: PW]) + xx * int'(xs[c*PW +: PW])
                                        + yy * int'(ys[c*PW +: PW]));
                mdir.push_back(d);
                maddr.push_back(base + 32'((yy * w + xx) * 4));
                mlast.push_back(yy == h - 1 && xx == w - 1);
            end
        end
        idx = 0;
    endtask

    // Entered and left at posedge+1; leaves the DUT one cycle after LOAD.
    task automatic start_frame(input bit scramble);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        rayTaken = 1'b0;
        @(negedge clock);
        check("load_ready", ready, 0);
        check("load_valid", rayValid, 0);
        @(posedge clock); #1;
        if (scramble) begin
            width = 12'($urandom_range(1, 6)); height = 12'($urandom_range(1, 6));
            cameraQ = {16'($urandom), 16'($urandom), 16'($urandom)};
            cameraV = {16'($urandom), 16'($urandom), 16'($urandom)};
            cameraX = {16'($urandom), 16'($urandom), 16'($urandom)};
            cameraY = {16'($urandom), 16'($urandom), 16'($urandom)};
            frameAddress = $urandom;
        end
    endtask

    // mode 0: always taken, 1: toggle starting at 0, 2: random.
    task automatic run_beats(input int mode, input int stop_at);
        int   cyc = 0;
        bit   stalled = 1'b0;
        vec3  pdir;
        logic [AW-1:0] paddr;
        logic plast;
        while (idx < stop_at && cyc < 400) begin
            rayTaken = (mode == 0) ? 1'b1 : (mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
            @(negedge clock);
            check("valid_in_frame", rayValid, 1);
            if (stalled) begin
                check("stall_dir", rayDirection, pdir);
                check("stall_addr", rayPixelAddress, paddr);
                check("stall_last", rayLast, plast);
            end
            if (rayValid && rayTaken) begin
                check($sformatf("dir[%0d]", idx), rayDirection, mdir[idx]);
                check($sformatf("addr[%0d]", idx), rayPixelAddress, maddr[idx]);
                check($sformatf("origin[%0d]", idx), rayOrigin, morigin);
                check($sformatf("last[%0d]", idx), rayLast, mlast[idx]);
                check("busy_in_frame", busy, 1);
                idx++;
            end
            stalled = rayValid && !rayTaken;
            pdir = rayDirection; paddr = rayPixelAddress; plast = rayLast;
            cyc++;
            @(posedge clock); #1;
        end
        if (idx < stop_at) check("beat_timeout", 64'(idx), 64'(stop_at));
        rayTaken = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clock);
        check({tag, "_ready"}, ready, 1);
        check({tag, "_valid"}, rayValid, 0);
        check({tag, "_busy"}, busy, 0);
        @(posedge clock); #1;
    endtask

    task automatic full_frame(input int mode, input bit scramble, input string tag);
        start_frame(scramble);
        run_beats(mode, mdir.size());
        check_idle(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", rayValid, 0);
        check("rst_last", rayLast, 0);
        check("rst_dir", rayDirection, 0);
        check("rst_origin", rayOrigin, 0);
        check("rst_addr", rayPixelAddress, 0);
        @(posedge clock); #1;
        resetN = 1'b1;
        @(posedge clock); #1;

        // Basic 2x2 frame
        set_config(2, 2, vec(5, 6, 7), vec(0, 0, 100), vec(1, 0, 0), vec(0, 1, 0), 32'h1000);
        full_frame(0, 1'b0, "basic_end");

        // Backpressure, toggling rayTaken
        set_config(2, 2, vec(5, 6, 7), vec(0, 0, 100), vec(1, 0, 0), vec(0, 1, 0), 32'h1000);
        full_frame(1, 1'b0, "bp_end");

        // Degenerate frame
        set_config(0, 5, vec(1, 2, 3), vec(4, 5, 6), vec(1, 1, 1), vec(1, 1, 1), 32'h2000);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        check("degen_ready_c1", ready, 0);
        check("degen_valid_c1", rayValid, 0);
        @(posedge clock); #1;
        @(negedge clock);
        check("degen_ready_c2", ready, 1);
        for (int i = 0; i < 4; i++) begin
            check("degen_valid", rayValid, 0);
            @(negedge clock);
        end
        @(posedge clock); #1;

        // Modular wrap
        set_config(2, 1, vec(0, 0, 0), vec(16'hFFFF, 0, 0), vec(1, 0, 0), vec(0, 0, 0), 32'h0);
        full_frame(0, 1'b0, "wrap_end");

        // Flush after 2nd beat, start ignored while busy, flush beats start
        set_config(3, 3, vec(9, 8, 7), vec(10, 20, 30), vec(2, 0, 1), vec(0, 3, 1), 32'h8000);
        start_frame(1'b0);
        start = 1'b1;
        run_beats(0, 2);
        flush = 1'b1; rayTaken = 1'b1; start = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0; rayTaken = 1'b0; start = 1'b0;
        check_idle("flush");
        check_idle("flush_nostart");
        set_config(3, 3, vec(9, 8, 7), vec(10, 20, 30), vec(2, 0, 1), vec(0, 3, 1), 32'h8000);
        full_frame(0, 1'b0, "restart_end");

        // Reset mid-frame
        set_config(3, 2, vec(1, 1, 1), vec(50, 60, 70), vec(1, 2, 3), vec(4, 5, 6), 32'h400);
        start_frame(1'b0);
        run_beats(0, 1);
        resetN = 1'b0;
        @(posedge clock); #1;
        resetN = 1'b1;
        @(negedge clock);
        check("midrst_valid", rayValid, 0);
        check("midrst_ready", ready, 1);
        check("midrst_dir", rayDirection, 0);
        check("midrst_addr", rayPixelAddress, 0);
        @(posedge clock); #1;

        // Random frames with random backpressure and config churn after LOAD
        for (int f = 0; f < 8; f++) begin
            int w, h;
            w = (f == 0) ? 1 : $urandom_range(1, 5);
            h = (f == 0) ? 1 : $urandom_range(1, 5);
            set_config(w, h, {16'($urandom), 16'($urandom), 16'($urandom)},
                       {16'($urandom), 16'($urandom), 16'($urandom)},
                       {16'($urandom), 16'($urandom), 16'($urandom)},
                       {16'($urandom), 16'($urandom), 16'($urandom)}, $urandom);
            full_frame(2, 1'b1, "rand_end");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
